// File: rtl/inst_id_pkg.sv
// Shared types and constant helpers for the instance-identity scanner.
package inst_id_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned ipow(input int unsigned base, input int unsigned exp);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    // Bits needed to index n items; never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/inst_id_rec.sv
// Combinational record formatter: leaf index (and ID) to tags, last flag and parity.
// Parity output and ID input exist only when INST_ID_SCAN_PARITY_EN is defined.
module inst_id_rec
    import inst_id_pkg::*;
#(
    parameter int unsigned NLEAF   = 16,
    parameter int unsigned LW      = 4,
    parameter int unsigned ID_W    = 32,
    parameter int unsigned TAG_W   = 16,
    parameter int unsigned P1_BASE = 100
) (
    input  logic [LW-1:0]    leaf,
`ifdef INST_ID_SCAN_PARITY_EN
    input  logic [ID_W-1:0]  id,
    output logic             par_c,
`endif
    output logic [TAG_W-1:0] p1_c,
    output logic [TAG_W-1:0] p2_c,
    output logic             last_c
);

    // Tags advance by two per leaf so p1/p2 never collide across leaves.
    always_comb begin
        p1_c   = TAG_W'(P1_BASE) + TAG_W'({leaf, 1'b0});
        p2_c   = p1_c + TAG_W'(1);
        last_c = (leaf == LW'(NLEAF - 1));
    end

`ifdef INST_ID_SCAN_PARITY_EN
    assign par_c = ^{id, p1_c, p2_c};
`endif

endmodule

// File: rtl/inst_id_scan.sv
// Instance-identity scanner: walks every leaf of a FANOUT-ary, DEPTH-level tree
// and streams one identity record per leaf. Optional out_par via INST_ID_SCAN_PARITY_EN.
module inst_id_scan
    import inst_id_pkg::*;
#(
    parameter int unsigned FANOUT  = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ID_W    = 32,
    parameter int unsigned TAG_W   = 16,
    parameter int unsigned P1_BASE = 100,
    localparam int unsigned NLEAF  = ipow(FANOUT, DEPTH),
    localparam int unsigned LW     = clog2_min1(NLEAF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ID_W-1:0]  root_id,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW-1:0]    out_leaf,
    output logic [ID_W-1:0]  out_id,
    output logic [TAG_W-1:0] out_p1,
    output logic [TAG_W-1:0] out_p2,
`ifdef INST_ID_SCAN_PARITY_EN
    output logic             out_par,
`endif
    output logic             out_last
);

    localparam logic [LW-1:0]   LAST_LEAF = LW'(NLEAF - 1);
    localparam logic [ID_W-1:0] NLEAF_ID  = ID_W'(NLEAF);

    state_t          state_q, state_d;
    logic [ID_W-1:0] root_q, root_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [LW-1:0]   leaf_q, leaf_d;
    logic            emit_d;
    logic [TAG_W-1:0] p1_c, p2_c;
    logic            last_c;
`ifdef INST_ID_SCAN_PARITY_EN
    logic            par_c;
`endif

    // Next-state and next-datapath logic.
    always_comb begin
        state_d = state_q;
        root_d  = root_q;
        id_d    = id_q;
        leaf_d  = leaf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    root_d  = root_id;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                id_d    = root_q * NLEAF_ID;
                leaf_d  = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    if (leaf_q == LAST_LEAF) begin
                        state_d = DONE;
                    end else begin
                        leaf_d = leaf_q + LW'(1);
                        id_d   = id_q + ID_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        emit_d = (state_d == EMIT);
    end

    // Record fields are formatted from next-cycle values so outputs register with them.
    inst_id_rec #(
        .NLEAF   (NLEAF),
        .LW      (LW),
        .ID_W    (ID_W),
        .TAG_W   (TAG_W),
        .P1_BASE (P1_BASE)
    ) u_rec (
        .leaf   (leaf_d),
`ifdef INST_ID_SCAN_PARITY_EN
        .id     (id_d),
        .par_c  (par_c),
`endif
        .p1_c   (p1_c),
        .p2_c   (p2_c),
        .last_c (last_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_q    <= '0;
            id_q      <= '0;
            leaf_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_leaf  <= '0;
            out_id    <= '0;
            out_p1    <= '0;
            out_p2    <= '0;
            out_last  <= 1'b0;
`ifdef INST_ID_SCAN_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            root_q    <= root_d;
            id_q      <= id_d;
            leaf_q    <= leaf_d;
            busy      <= (state_d == LOAD) || (state_d == EMIT);
            done      <= (state_d == DONE);
            out_valid <= emit_d;
            out_leaf  <= emit_d ? leaf_d : '0;
            out_id    <= emit_d ? id_d   : '0;
            out_p1    <= emit_d ? p1_c   : '0;
            out_p2    <= emit_d ? p2_c   : '0;
            out_last  <= emit_d & last_c;
`ifdef INST_ID_SCAN_PARITY_EN
            out_par   <= emit_d & par_c;
`endif
        end
    end

endmodule

// File: tb/tb_inst_id_scan.sv
// Self-checking bench for inst_id_scan: default tree (2-ary, depth 4) and a
// 3-ary depth-2 tree with 8-bit IDs, checked against an arithmetic leaf model.
module tb_inst_id_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: defaults
    logic [31:0] a_root;
    logic        a_start, a_ready;
    logic        a_busy, a_done, a_valid, a_last;
    logic [3:0]  a_leaf;
    logic [31:0] a_id;
    logic [15:0] a_p1, a_p2;
`ifdef INST_ID_SCAN_PARITY_EN
    logic        a_par;
`endif

    // DUT B: FANOUT=3, DEPTH=2, ID_W=8
    logic [7:0]  b_root;
    logic        b_start, b_ready;
    logic        b_busy, b_done, b_valid, b_last;
    logic [3:0]  b_leaf;
    logic [7:0]  b_id;
    logic [15:0] b_p1, b_p2;
`ifdef INST_ID_SCAN_PARITY_EN
    logic        b_par;
`endif

    inst_id_scan dut_a (
        .clk(clk), .rst_n(rst_n), .root_id(a_root), .start(a_start),
        .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(a_ready),
        .out_leaf(a_leaf), .out_id(a_id), .out_p1(a_p1), .out_p2(a_p2),
`ifdef INST_ID_SCAN_PARITY_EN
        .out_par(a_par),
`endif
        .out_last(a_last)
    );

    inst_id_scan #(.FANOUT(3), .DEPTH(2), .ID_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .root_id(b_root), .start(b_start),
        .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(b_ready),
        .out_leaf(b_leaf), .out_id(b_id), .out_p1(b_p1), .out_p2(b_p2),
`ifdef INST_ID_SCAN_PARITY_EN
        .out_par(b_par),
`endif
        .out_last(b_last)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaf L of a tree rooted at root has ID root*fan^dep + L, wrapped to idw bits.
    function automatic longint unsigned model_id(input longint unsigned root, input int unsigned fan,
                                                 input int unsigned dep, input int unsigned idw,
                                                 input int unsigned l);
        longint unsigned n;
        n = 1;
        for (int i = 0; i < int'(dep); i++) n = n * fan;
        return (root * n + l) & ((64'd1 << idw) - 1);
    endfunction

    function automatic longint unsigned model_p1(input int unsigned l);
        return (100 + 2 * l) & 16'hFFFF;
    endfunction

    function automatic longint unsigned model_p2(input int unsigned l);
        return (101 + 2 * l) & 16'hFFFF;
    endfunction

    function automatic longint unsigned model_par(input longint unsigned id, input int unsigned l);
        logic [63:0] cat;
        cat = {32'(id), 16'(model_p1(l)), 16'(model_p2(l))};
        return 64'(^cat);
    endfunction

    task automatic check_a_idle_outputs(input string tag);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_leaf"},  a_leaf,  0);
        check({tag, "_id"},    a_id,    0);
        check({tag, "_p1"},    a_p1,    0);
        check({tag, "_p2"},    a_p2,    0);
        check({tag, "_last"},  a_last,  0);
`ifdef INST_ID_SCAN_PARITY_EN
        check({tag, "_par"},   a_par,   0);
`endif
    endtask

    // mode 0: ready always, 1: random ready, 2: 1-0-0-1 ready pattern.
    // disturb: toggle start and root_id while not idle.
    task automatic scan_a(input logic [31:0] root, input int mode, input bit disturb);
        int exp_l;
        int cyc;
        bit rdy;
        exp_l = 0;
        cyc = 0;
        @(negedge clk);
        a_root  = root;
        a_start = 1'b1;
        @(negedge clk);
        a_start = disturb;
        if (disturb) a_root = $urandom;
        check("load_busy", a_busy, 1);
        check_a_idle_outputs("load");
        a_ready = 1'b1;
        while (exp_l < 16 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            check("emit_valid", a_valid, 1);
            check("emit_busy",  a_busy,  1);
            check("emit_done",  a_done,  0);
            check("leaf", a_leaf, longint'(exp_l));
            check("id",   a_id,   model_id(root, 2, 4, 32, exp_l));
            check("p1",   a_p1,   model_p1(exp_l));
            check("p2",   a_p2,   model_p2(exp_l));
            check("last", a_last, longint'(exp_l == 15));
`ifdef INST_ID_SCAN_PARITY_EN
            check("par",  a_par,  model_par(model_id(root, 2, 4, 32, exp_l), exp_l));
`endif
            case (mode)
                1:       rdy = 1'($urandom % 2);
                2:       rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: rdy = 1'b1;
            endcase
            a_ready = rdy;
            if (disturb) begin
                a_start = 1'($urandom % 2);
                a_root  = $urandom;
            end
            if (rdy) exp_l++;
        end
        if (exp_l < 16) check("emit_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", a_done, 1);
        check("done_busy",  a_busy, 0);
        check_a_idle_outputs("done");
        a_ready = 1'b0;
        a_start = disturb;
        @(negedge clk);
        check("post_done", a_done, 0);
        check("post_busy", a_busy, 0);
        a_start = 1'b0;
        @(negedge clk);
        check("idle_busy", a_busy, 0);
        check_a_idle_outputs("idle");
    endtask

    task automatic scan_b(input logic [7:0] root);
        int exp_l;
        int cyc;
        exp_l = 0;
        cyc = 0;
        @(negedge clk);
        b_root  = root;
        b_start = 1'b1;
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_root  = ~root;
        check("b_load_valid", b_valid, 0);
        while (exp_l < 9 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check("b_valid", b_valid, 1);
            check("b_leaf",  b_leaf,  longint'(exp_l));
            check("b_id",    b_id,    model_id(root, 3, 2, 8, exp_l));
            check("b_p1",    b_p1,    model_p1(exp_l));
            check("b_p2",    b_p2,    model_p2(exp_l));
            check("b_last",  b_last,  longint'(exp_l == 8));
            exp_l++;
        end
        @(negedge clk);
        check("b_done",  b_done,  1);
        check("b_busy",  b_busy,  0);
        check("b_valid_done", b_valid, 0);
        @(negedge clk);
        check("b_post_done", b_done, 0);
    endtask

    task automatic reset_mid_scan(input logic [31:0] root);
        int cyc;
        cyc = 0;
        @(negedge clk);
        a_root  = root;
        a_start = 1'b1;
        a_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        while (!(a_valid && a_leaf == 4'd5) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_l5", a_leaf, 5);
        rst_n = 1'b0;
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check_a_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done",  a_done,  0);
            check("rst_no_busy",  a_busy,  0);
            check("rst_no_valid", a_valid, 0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_root  = '0; a_start = 1'b0; a_ready = 1'b0;
        b_root  = '0; b_start = 1'b0; b_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", a_busy, 0);
        check("reset_done", a_done, 0);
        check_a_idle_outputs("reset");
        check("reset_b_valid", b_valid, 0);
        rst_n = 1'b1;

        scan_a(32'd0, 0, 1'b0);
        scan_a(32'd1, 0, 1'b0);
        scan_a(32'hFFFF_FFFF, 1, 1'b0);
        scan_a($urandom, 2, 1'b0);
        scan_a($urandom, 1, 1'b1);
        reset_mid_scan(32'd7);
        scan_a(32'd7, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            scan_a($urandom, int'($urandom % 3), 1'($urandom % 2));
        end

        scan_b(8'd3);
        scan_b(8'd28);
        scan_b(8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
